// File: rtl/quad_encoder_counter.sv
// Quadrature encoder front end: 2-flop sync, per-channel debounce, A-rise detent decode, value counter.
// Define ENC_SATURATE_EN to clamp the counter at 0 and 2^WIDTH-1 instead of wrapping.
module quad_encoder_counter #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned STEP            = 1,
    parameter int unsigned RESET_VALUE     = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc_a,
    input  logic             enc_b,
    output logic [WIDTH-1:0] value,
    output logic             up_pulse,
    output logic             down_pulse,
    output logic             a_db,
    output logic             b_db
);

    localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0]  STEP_V   = WIDTH'(STEP);
    localparam logic [WIDTH-1:0]  RESET_V  = WIDTH'(RESET_VALUE);

    // Bit 0 is channel A, bit 1 is channel B.
    logic [1:0]       raw;
    logic [1:0]       s1;
    logic [1:0]       s2;
    logic [1:0]       db;
    logic [CNT_W-1:0] cnt [2];
    logic             a_db_q;

    logic             detent_c;
    logic [WIDTH-1:0] inc_c;
    logic [WIDTH-1:0] dec_c;

    assign raw  = {enc_b, enc_a};
    assign a_db = db[0];
    assign b_db = db[1];

    // Synchronise, then require CNT_LAST+1 consecutive disagreeing samples before db follows.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            db <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // A detent is a debounced rising edge of A; B level at that cycle gives direction.
    assign detent_c = db[0] & ~a_db_q;

`ifdef ENC_SATURATE_EN
    logic [WIDTH:0] sum_ext_c;

    always_comb begin
        sum_ext_c = {1'b0, value} + {1'b0, STEP_V};
        inc_c     = sum_ext_c[WIDTH] ? '1 : sum_ext_c[WIDTH-1:0];
        dec_c     = (value < STEP_V) ? '0 : (value - STEP_V);
    end
`else
    always_comb begin
        inc_c = value + STEP_V;
        dec_c = value - STEP_V;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            a_db_q     <= 1'b0;
            value      <= RESET_V;
            up_pulse   <= 1'b0;
            down_pulse <= 1'b0;
        end else begin
            a_db_q     <= db[0];
            up_pulse   <= detent_c & ~db[1];
            down_pulse <= detent_c &  db[1];
            if (detent_c) begin
                value <= db[1] ? dec_c : inc_c;
            end
        end
    end

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Bench for quad_encoder_counter: a STEP=1 instance and a STEP=4/RESET_VALUE=254 instance share inputs.
// Expected detents are queued at stimulus time and matched against pulses as they appear.
module tb_quad_encoder_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enc_a = 1'b0;
    logic       enc_b = 1'b0;

    logic [7:0] value0, value1;
    logic       up0, dn0, up1, dn1;
    logic       a_db0, b_db0, a_db1, b_db1;

    int unsigned cyc = 0;
    int          n_total = 0;
    int          n_pass = 0;

    logic [7:0] m0 = 8'd0;
    logic [7:0] m1 = 8'd254;

    typedef struct {
        int unsigned cyc;
        logic        up;
        logic [7:0]  v0;
        logic [7:0]  v1;
    } exp_t;

    exp_t q[$];
    exp_t e;

    quad_encoder_counter #(
        .WIDTH(8), .DEBOUNCE_CYCLES(4), .STEP(1), .RESET_VALUE(0)
    ) dut0 (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
        .value(value0), .up_pulse(up0), .down_pulse(dn0), .a_db(a_db0), .b_db(b_db0)
    );

    quad_encoder_counter #(
        .WIDTH(8), .DEBOUNCE_CYCLES(4), .STEP(4), .RESET_VALUE(254)
    ) dut1 (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
        .value(value1), .up_pulse(up1), .down_pulse(dn1), .a_db(a_db1), .b_db(b_db1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [7:0] nxt(input logic [7:0] v, input logic up, input logic [7:0] st);
`ifdef ENC_SATURATE_EN
        logic [8:0] s;
        if (up) begin
            s = {1'b0, v} + {1'b0, st};
            return s[8] ? 8'hFF : s[7:0];
        end
        return (v < st) ? 8'h00 : (v - st);
`else
        return up ? (v + st) : (v - st);
`endif
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int unsigned when, input logic up);
        exp_t x;
        m0 = nxt(m0, up, 8'd1);
        m1 = nxt(m1, up, 8'd4);
        x.cyc = when;
        x.up  = up;
        x.v0  = m0;
        x.v1  = m1;
        q.push_back(x);
    endtask

    task automatic do_reset(input int n);
        enc_a = 1'b0;
        enc_b = 1'b0;
        reset = 1'b1;
        step(n);
        reset = 1'b0;
        m0 = 8'd0;
        m1 = 8'd254;
    endtask

    // Set direction on B, raise A, check debounce timing, then release A.
    task automatic detent(input logic down, input string tag);
        int unsigned t;
        enc_b = down;
        step(10);
        enc_a = 1'b1;
        t = cyc;
        push(t + 7, !down);
        step(5);
        @(negedge clk);
        check({tag, "_adb_early"}, 32'(a_db0), 32'd0);
        step(1);
        @(negedge clk);
        check({tag, "_adb_on_time"}, 32'(a_db0), 32'd1);
        check({tag, "_bdb"}, 32'(b_db0), 32'(down));
        step(6);
        enc_a = 1'b0;
        step(10);
    endtask

    // Scoreboard: every pulse must match the oldest queued detent.
    always @(negedge clk) begin
        if (up0 | dn0 | up1 | dn1) begin
            check("pulse_exclusive", 32'(up0 & dn0), 32'd0);
            if (q.size() == 0) begin
                check("spurious_pulse", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("up0", 32'(up0), 32'(e.up));
                check("dn0", 32'(dn0), 32'(!e.up));
                check("value0", 32'(value0), 32'(e.v0));
                check("up1", 32'(up1), 32'(e.up));
                check("value1", 32'(value1), 32'(e.v1));
            end
        end
    end

    initial begin
        int unsigned t;
        int unsigned rel;

        // Reset and idle.
        do_reset(3);
        step(10);
        @(negedge clk);
        check("rst_value0", 32'(value0), 32'd0);
        check("rst_value1", 32'(value1), 32'd254);
        check("rst_adb", 32'(a_db0), 32'd0);
        check("rst_bdb", 32'(b_db0), 32'd0);
        check("rst_pulses", 32'({up0, dn0, up1, dn1}), 32'd0);

        // Ten clockwise detents; the STEP=4 instance wraps/clamps at its first one.
        for (int i = 0; i < 10; i++) begin
            detent(1'b0, "cw");
        end
        @(negedge clk);
        check("cw10_value0", 32'(value0), 32'd10);

        // Bouncy A rise: only the final stable rise counts.
        enc_b = 1'b0;
        step(10);
        enc_a = 1'b1; step(1);
        enc_a = 1'b0; step(1);
        enc_a = 1'b1; step(1);
        enc_a = 1'b0; step(1);
        enc_a = 1'b1;
        t = cyc;
        push(t + 7, 1'b1);
        step(15);
        enc_a = 1'b0;
        step(10);
        @(negedge clk);
        check("bounce_value0", 32'(value0), 32'd11);

        // Down from 0, then up from the result.
        do_reset(2);
        step(5);
        detent(1'b1, "ccw_from0");
        detent(1'b0, "cw_back");

        // Reset while a debounce is in flight, then let the held level debounce.
        enc_b = 1'b0;
        step(10);
        enc_a = 1'b1;
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        rel = cyc;
        m0 = 8'd0;
        m1 = 8'd254;
        push(rel + 7, 1'b1);
        @(negedge clk);
        check("midrst_value0", 32'(value0), 32'd0);
        check("midrst_value1", 32'(value1), 32'd254);
        check("midrst_adb", 32'(a_db0), 32'd0);
        step(15);
        @(negedge clk);
        check("midrst_final0", 32'(value0), 32'd1);
        enc_a = 1'b0;

        for (int i = 0; i < 50 && q.size() > 0; i++) begin
            step(1);
        end
        step(10);
        check("drain", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
